// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the hardwired control sequencer.
// Opcodes, ALU codes, bus selects, FSM states and the control bundle.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T1W,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_RTYPE,
        CLS_ITYPE,
        CLS_LDI,
        CLS_HALT
    } op_class_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_ANDI = 5'b01001;
    localparam logic [4:0] OP_ORI  = 5'b01010;
    localparam logic [4:0] OP_LDI  = 5'b01011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;

    localparam logic [4:0] BUS_NONE = 5'b00000;
    localparam logic [4:0] BUS_ZLO  = 5'b10011;
    localparam logic [4:0] BUS_PC   = 5'b10100;
    localparam logic [4:0] BUS_MDR  = 5'b10101;

    typedef struct packed {
        logic       inc_pc;
        logic       e_pc;
        logic       e_ir;
        logic       e_y;
        logic       e_z;
        logic       e_mdr;
        logic       e_mar;
        logic       mdr_read;
        logic       ram_read;
        logic       ram_write;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       e_rin;
        logic       e_rout;
        logic       ba_out;
        logic       imm_sel;
        logic       halted;
        logic [3:0] alu_op;
        logic [4:0] bus_sel;
    } ctrl_t;

endpackage

// File: rtl/op_decode.sv
// Opcode classifier: maps a 5-bit opcode to its execution class
// and the ALU operation used in T4.
module op_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class,
    output logic [3:0] alu_op
);

    always_comb begin
        op_class = CLS_NOP;
        alu_op   = ALU_NONE;
        unique case (1'b1)
            (opcode == OP_ADD):  begin op_class = CLS_RTYPE; alu_op = ALU_ADD; end
            (opcode == OP_SUB):  begin op_class = CLS_RTYPE; alu_op = ALU_SUB; end
            (opcode == OP_AND):  begin op_class = CLS_RTYPE; alu_op = ALU_AND; end
            (opcode == OP_OR):   begin op_class = CLS_RTYPE; alu_op = ALU_OR;  end
            (opcode == OP_ADDI): begin op_class = CLS_ITYPE; alu_op = ALU_ADD; end
            (opcode == OP_ANDI): begin op_class = CLS_ITYPE; alu_op = ALU_AND; end
            (opcode == OP_ORI):  begin op_class = CLS_ITYPE; alu_op = ALU_OR;  end
            (opcode == OP_LDI):  begin op_class = CLS_LDI;   alu_op = ALU_ADD; end
            (opcode == OP_HALT): op_class = CLS_HALT;
            default:             op_class = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore-style hardwired control unit: fetch T0-T2, execute T3-T5.
// Define CU_MEM_WAIT_EN to stretch T1W until mem_ready.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        incPC,
    output logic        e_PC,
    output logic        e_IR,
    output logic        e_Y,
    output logic        e_Z,
    output logic        e_MDR,
    output logic        e_MAR,
    output logic        MDR_read,
    output logic        ram_read,
    output logic        ram_write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        e_Rin,
    output logic        e_Rout,
    output logic        BAout,
    output logic        imm_sel,
    output logic        halted,
    output logic [3:0]  ALU_op,
    output logic [4:0]  BusDataSelect,
    output logic [15:0] instr_count
);

    state_t     state;
    state_t     nxt;
    logic [4:0] op_q;
    logic       retire;
    op_class_t  cls;
    logic [3:0] dec_alu;
    ctrl_t      ctl;

    logic [26:0] ir_unused;
    assign ir_unused = ir[26:0];

    op_decode u_dec (
        .opcode   (op_q),
        .op_class (cls),
        .alu_op   (dec_alu)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= S_IDLE;
            op_q        <= 5'b0;
            instr_count <= 16'h0;
        end else begin
            state <= nxt;
            if (state == S_T2)
                op_q <= ir[31:27];
            if (retire)
                instr_count <= instr_count + 16'd1;
        end
    end

`ifndef CU_MEM_WAIT_EN
    logic mem_ready_unused;
    assign mem_ready_unused = mem_ready;
`endif

    always_comb begin
        nxt    = state;
        retire = 1'b0;
        ctl    = '0;
        unique case (state)
            S_IDLE: if (run) nxt = S_T0;
            S_T0: begin
                ctl.bus_sel = BUS_PC;
                ctl.e_mar   = 1'b1;
                ctl.inc_pc  = 1'b1;
                nxt         = S_T1;
            end
            S_T1: begin
                ctl.ram_read = 1'b1;
                nxt          = S_T1W;
            end
            S_T1W: begin
                ctl.mdr_read = 1'b1;
                ctl.e_mdr    = 1'b1;
`ifdef CU_MEM_WAIT_EN
                if (mem_ready) nxt = S_T2;
`else
                nxt = S_T2;
`endif
            end
            S_T2: begin
                ctl.bus_sel = BUS_MDR;
                ctl.e_ir    = 1'b1;
                nxt         = S_T3;
            end
            S_T3: begin
                unique case (cls)
                    CLS_RTYPE, CLS_ITYPE: begin
                        ctl.grb    = 1'b1;
                        ctl.e_rout = 1'b1;
                        ctl.e_y    = 1'b1;
                        nxt        = S_T4;
                    end
                    CLS_LDI: begin
                        ctl.grb    = 1'b1;
                        ctl.ba_out = 1'b1;
                        ctl.e_y    = 1'b1;
                        nxt        = S_T4;
                    end
                    CLS_HALT: nxt = S_HALT;
                    default: begin
                        nxt    = S_T0;
                        retire = 1'b1;
                    end
                endcase
            end
            S_T4: begin
                ctl.alu_op = dec_alu;
                ctl.e_z    = 1'b1;
                if (cls == CLS_RTYPE) begin
                    ctl.grc    = 1'b1;
                    ctl.e_rout = 1'b1;
                end
                if (cls == CLS_ITYPE || cls == CLS_LDI)
                    ctl.imm_sel = 1'b1;
                nxt = S_T5;
            end
            S_T5: begin
                ctl.bus_sel = BUS_ZLO;
                ctl.gra     = 1'b1;
                ctl.e_rin   = 1'b1;
                nxt         = S_T0;
                retire      = 1'b1;
            end
            S_HALT: begin
                ctl.halted = 1'b1;
                if (run) nxt = S_T0;
            end
            default: nxt = S_IDLE;
        endcase
    end

    assign incPC         = ctl.inc_pc;
    assign e_PC          = ctl.e_pc;
    assign e_IR          = ctl.e_ir;
    assign e_Y           = ctl.e_y;
    assign e_Z           = ctl.e_z;
    assign e_MDR         = ctl.e_mdr;
    assign e_MAR         = ctl.e_mar;
    assign MDR_read      = ctl.mdr_read;
    assign ram_read      = ctl.ram_read;
    assign ram_write     = ctl.ram_write;
    assign Gra           = ctl.gra;
    assign Grb           = ctl.grb;
    assign Grc           = ctl.grc;
    assign e_Rin         = ctl.e_rin;
    assign e_Rout        = ctl.e_rout;
    assign BAout         = ctl.ba_out;
    assign imm_sel       = ctl.imm_sel;
    assign halted        = ctl.halted;
    assign ALU_op        = ctl.alu_op;
    assign BusDataSelect = ctl.bus_sel;

endmodule
